// File: rtl/fft_pkg.sv
// Shared types and fixed-point helpers for the streaming FFT stages.
// Component math uses a 32-bit signed container; callers pass their real component width.
package fft_pkg;

    localparam logic MODE_FFT  = 1'b0;
    localparam logic MODE_IFFT = 1'b1;

    localparam int CW = 32;

    typedef logic signed [CW-1:0] comp_t;
    typedef logic [2*CW-1:0]      cword_t;

    typedef struct packed {
        comp_t re;
        comp_t im;
    } cplx_t;

    typedef struct packed {
        comp_t val;
        logic  ovf;
    } sat_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_LOAD,
        OP_LOAD_DRAIN,
        OP_CALC,
        OP_DRAIN
    } bf_op_e;

    function automatic comp_t sext(input comp_t x, input int w);
        comp_t r;
        r = x <<< (CW - w);
        return r >>> (CW - w);
    endfunction

    // Word layout is {re, im}, each w bits wide.
    function automatic cplx_t cplx_unpack(input cword_t word, input int w);
        cplx_t c;
        c.re = sext(comp_t'(word >> w), w);
        c.im = sext(comp_t'(word), w);
        return c;
    endfunction

    function automatic cword_t cplx_pack(input cplx_t c, input int w);
        cword_t mask;
        mask = (cword_t'(1) << w) - cword_t'(1);
        return ((cword_t'(c.re) & mask) << w) | (cword_t'(c.im) & mask);
    endfunction

    function automatic sat_t sat_w(input comp_t x, input int w);
        sat_t  r;
        comp_t hi;
        comp_t lo;
        hi    = (comp_t'(1) <<< (w - 1)) - comp_t'(1);
        lo    = -hi - comp_t'(1);
        r.ovf = 1'b1;
        if (x > hi) begin
            r.val = hi;
        end else if (x < lo) begin
            r.val = lo;
        end else begin
            r.val = x;
            r.ovf = 1'b0;
        end
        return r;
    endfunction

    function automatic comp_t rnd_half(input comp_t x);
        return (x + comp_t'(1)) >>> 1;
    endfunction

    function automatic sat_t neg_sat(input comp_t x, input int w);
        return sat_w(-x, w);
    endfunction

    function automatic sat_t scale_sat(input comp_t x, input logic scale, input int w);
        return sat_w(scale ? rnd_half(x) : x, w);
    endfunction

endpackage

// File: rtl/bf_sdf_fifo.sv
// Circular delay buffer for the SDF feedback path; push and pop may coincide.
// Storage has no reset: only pointers and count are cleared.
module bf_sdf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [AW-1:0]    PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_FULL) || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/bf_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage with per-frame scaling,
// saturation, optional trivial -j/+j rotation of the late differences, and sync clear.
module bf_sdf_stage
    import fft_pkg::*;
#(
    parameter int FFT_STG     = 7,
    parameter int DATA_WIDTH  = 18,
    parameter int TOTAL_STAGE = 11,
    parameter int TRIV_ROT    = 0
) (
    input  logic                    iclk,
    input  logic                    rst,
    input  logic                    iclr,
    input  logic                    imode,
    input  logic                    iscale,
    input  logic                    ien,
    input  logic [TOTAL_STAGE-1:0]  iaddr,
    input  logic [2*DATA_WIDTH-1:0] idata,
    output logic                    oen,
    output logic [TOTAL_STAGE-1:0]  oaddr,
    output logic [2*DATA_WIDTH-1:0] odata,
    output logic                    oovf
);

    localparam int D     = 2 ** (FFT_STG - 1);
    localparam int DW    = DATA_WIDTH;
    localparam int FW    = 2 * DW + 1;
    localparam int CNT_W = $clog2(D + 1);
    localparam int JW    = (FFT_STG > 1) ? FFT_STG - 1 : 1;
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(D);
    localparam logic [JW-1:0]    J_LAST   = JW'(D - 1);
    localparam logic [JW-1:0]    J_HALF   = JW'(D / 2);

    logic [CNT_W-1:0]       r_pend;
    logic [JW-1:0]          r_j;
    logic                   r_scale;
    logic                   r_oen;
    logic                   r_oovf;
    logic [TOTAL_STAGE-1:0] r_oaddr;
    logic [2*DW-1:0]        r_odata;

    bf_op_e           w_op;
    logic             w_calc_phase;
    logic             w_k_zero;
    logic             w_push;
    logic             w_pop;
    logic             w_diff_pop;
    logic [FW-1:0]    w_head;
    logic [FW-1:0]    w_push_data;
    logic [CNT_W-1:0] w_fifo_cnt;
    cplx_t            w_a;
    cplx_t            w_b;
    cplx_t            w_sum;
    cplx_t            w_diff;
    cplx_t            w_rot;
    sat_t             w_s_re;
    sat_t             w_s_im;
    sat_t             w_d_re;
    sat_t             w_d_im;
    sat_t             w_neg;
    logic             w_sum_ovf;
    logic             w_diff_ovf;
    logic             w_rot_en;
    logic             w_rot_ovf;
    logic             w_unused_addr;

    assign w_calc_phase  = iaddr[FFT_STG-1];
    assign w_k_zero      = (iaddr[FFT_STG-1:0] == '0);
    assign w_unused_addr = ^iaddr;

    // Sync clear wins over any accept in the same cycle.
    always_comb begin
        w_op = OP_NONE;
        if (!iclr) begin
            if (ien && !w_calc_phase) begin
                w_op = (r_pend != '0) ? OP_LOAD_DRAIN : OP_LOAD;
            end else if (ien && w_calc_phase) begin
                w_op = (w_fifo_cnt != '0) ? OP_CALC : OP_NONE;
            end else if (!ien && (r_pend != '0)) begin
                w_op = OP_DRAIN;
            end
        end
    end

    assign w_push     = (w_op == OP_LOAD) || (w_op == OP_LOAD_DRAIN) || (w_op == OP_CALC);
    assign w_diff_pop = (w_op == OP_LOAD_DRAIN) || (w_op == OP_DRAIN);
    assign w_pop      = w_diff_pop || (w_op == OP_CALC);

    // Head holds a loaded sample during calc and a stored difference otherwise.
    always_comb begin
        w_a        = cplx_unpack(cword_t'(w_head[2*DW-1:0]), DW);
        w_b        = cplx_unpack(cword_t'(idata), DW);
        w_s_re     = scale_sat(w_a.re + w_b.re, r_scale, DW);
        w_s_im     = scale_sat(w_a.im + w_b.im, r_scale, DW);
        w_d_re     = scale_sat(w_a.re - w_b.re, r_scale, DW);
        w_d_im     = scale_sat(w_a.im - w_b.im, r_scale, DW);
        w_sum.re   = w_s_re.val;
        w_sum.im   = w_s_im.val;
        w_diff.re  = w_d_re.val;
        w_diff.im  = w_d_im.val;
        w_sum_ovf  = w_s_re.ovf | w_s_im.ovf;
        w_diff_ovf = w_d_re.ovf | w_d_im.ovf;
        if (w_op == OP_CALC) begin
            w_push_data = {w_diff_ovf, (2*DW)'(cplx_pack(w_diff, DW))};
        end else begin
            w_push_data = {1'b0, idata};
        end
    end

    always_comb begin
        w_rot_en  = (TRIV_ROT != 0) && (r_j >= J_HALF);
        w_rot     = w_a;
        w_neg     = '0;
        w_rot_ovf = 1'b0;
        if (w_rot_en) begin
            if (imode == MODE_FFT) begin
                w_neg    = neg_sat(w_a.re, DW);
                w_rot.re = w_a.im;
                w_rot.im = w_neg.val;
            end else begin
                w_neg    = neg_sat(w_a.im, DW);
                w_rot.re = w_neg.val;
                w_rot.im = w_a.re;
            end
            w_rot_ovf = w_neg.ovf;
        end
    end

    bf_sdf_fifo #(
        .DEPTH (D),
        .WIDTH (FW)
    ) u_fifo (
        .i_clk   (iclk),
        .i_rst   (rst),
        .i_clr   (iclr),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_data),
        .o_rdata (w_head),
        .o_count (w_fifo_cnt)
    );

    // r_j is the drain index of the next difference; drains always come in blocks of D.
    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_j     <= '0;
            r_scale <= 1'b0;
        end else if (iclr) begin
            r_pend  <= '0;
            r_j     <= '0;
            r_scale <= 1'b0;
        end else begin
            if (ien && w_k_zero) r_scale <= iscale;
            if ((w_op == OP_CALC) && (r_pend != PEND_MAX)) begin
                r_pend <= r_pend + 1'b1;
            end else if (w_diff_pop) begin
                r_pend <= r_pend - 1'b1;
            end
            if (w_diff_pop) r_j <= (r_j == J_LAST) ? '0 : r_j + 1'b1;
        end
    end

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            r_oen   <= 1'b0;
            r_oaddr <= '1;
            r_odata <= '0;
            r_oovf  <= 1'b0;
        end else if (iclr) begin
            r_oen   <= 1'b0;
            r_oaddr <= '1;
            r_odata <= '0;
            r_oovf  <= 1'b0;
        end else begin
            r_oen   <= w_pop;
            r_oaddr <= w_pop ? r_oaddr + 1'b1 : '1;
            if (w_op == OP_CALC) begin
                r_odata <= (2*DW)'(cplx_pack(w_sum, DW));
                r_oovf  <= w_sum_ovf;
            end else if (w_diff_pop) begin
                r_odata <= (2*DW)'(cplx_pack(w_rot, DW));
                r_oovf  <= w_head[FW-1] | w_rot_ovf;
            end else begin
                r_odata <= '0;
                r_oovf  <= 1'b0;
            end
        end
    end

    assign oen   = r_oen;
    assign oaddr = r_oaddr;
    assign odata = r_odata;
    assign oovf  = r_oovf;

endmodule

// File: tb/tb_bf_sdf_stage.sv
// Bench for bf_sdf_stage: plain and rotating instances share stimulus and are checked
// every cycle against a queue-based model of the butterfly stage.
module tb_bf_sdf_stage;

    localparam int D = 4;

    logic        iclk = 1'b0;
    logic        rst;
    logic        iclr;
    logic        imode;
    logic        iscale;
    logic        ien;
    logic [2:0]  iaddr;
    logic [15:0] idata;

    logic        oen0, oen1;
    logic [2:0]  oaddr0, oaddr1;
    logic [15:0] odata0, odata1;
    logic        oovf0, oovf1;

    bf_sdf_stage #(.FFT_STG(3), .DATA_WIDTH(8), .TOTAL_STAGE(3), .TRIV_ROT(0)) u_dut (
        .iclk(iclk), .rst(rst), .iclr(iclr), .imode(imode), .iscale(iscale), .ien(ien),
        .iaddr(iaddr), .idata(idata), .oen(oen0), .oaddr(oaddr0), .odata(odata0), .oovf(oovf0)
    );

    bf_sdf_stage #(.FFT_STG(3), .DATA_WIDTH(8), .TOTAL_STAGE(3), .TRIV_ROT(1)) u_dut_rot (
        .iclk(iclk), .rst(rst), .iclr(iclr), .imode(imode), .iscale(iscale), .ien(ien),
        .iaddr(iaddr), .idata(idata), .oen(oen1), .oaddr(oaddr1), .odata(odata1), .oovf(oovf1)
    );

    always #5 iclk = ~iclk;

    int    n_checks = 0;
    int    n_errors = 0;
    string cur_test = "init";

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (oen,oaddr,re,im,oovf)", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int re; int im; } smp_t;
    typedef struct { int re; int im; bit ovf; int idx; } diff_t;

    smp_t  half_q[$];
    diff_t diff_q[$];
    int    m_oaddr = 7;
    bit    m_scale = 1'b0;

    function automatic void clip(input int x, output int y, output bit o);
        if (x > 127) begin
            y = 127; o = 1'b1;
        end else if (x < -128) begin
            y = -128; o = 1'b1;
        end else begin
            y = x; o = 1'b0;
        end
    endfunction

    function automatic int halve(input int x, input bit sc);
        return sc ? int'($floor((x + 1) / 2.0)) : x;
    endfunction

    function automatic int s8(input logic [7:0] v);
        return int'(signed'(v));
    endfunction

    task automatic model_cycle(output logic [20:0] e_plain, output logic [20:0] e_rot);
        int    k, bre, bim;
        int    p_re, p_im, q_re, q_im;
        bit    p_ovf, q_ovf, o1, o2, emit, take_diff;
        smp_t  a;
        smp_t  s;
        diff_t d;
        e_plain = {1'b0, 3'b111, 16'h0000, 1'b0};
        e_rot   = e_plain;
        if (rst || iclr) begin
            half_q.delete();
            diff_q.delete();
            m_oaddr = 7;
            m_scale = 1'b0;
            return;
        end
        emit = 0; take_diff = 0;
        p_re = 0; p_im = 0; p_ovf = 0;
        k   = int'(iaddr);
        bre = s8(idata[15:8]);
        bim = s8(idata[7:0]);
        if (ien && k == 0) m_scale = iscale;
        if (ien && k < D) begin
            s.re = bre;
            s.im = bim;
            half_q.push_back(s);
            take_diff = (diff_q.size() > 0);
        end else if (ien && half_q.size() > 0) begin
            a = half_q.pop_front();
            clip(halve(a.re + bre, m_scale), p_re, o1);
            clip(halve(a.im + bim, m_scale), p_im, o2);
            p_ovf = o1 | o2;
            emit  = 1;
            clip(halve(a.re - bre, m_scale), d.re, o1);
            clip(halve(a.im - bim, m_scale), d.im, o2);
            d.ovf = o1 | o2;
            d.idx = k - D;
            diff_q.push_back(d);
        end else if (!ien) begin
            take_diff = (diff_q.size() > 0);
        end
        q_re = p_re; q_im = p_im; q_ovf = p_ovf;
        if (take_diff) begin
            d     = diff_q.pop_front();
            emit  = 1;
            p_re  = d.re; p_im = d.im; p_ovf = d.ovf;
            q_re  = d.re; q_im = d.im; q_ovf = d.ovf;
            if (d.idx >= D / 2) begin
                if (imode == 1'b0) begin
                    q_re = d.im;
                    clip(-d.re, q_im, o1);
                end else begin
                    clip(-d.im, q_re, o1);
                    q_im = d.re;
                end
                q_ovf = d.ovf | o1;
            end
        end
        if (emit) begin
            m_oaddr = (m_oaddr + 1) % 8;
            e_plain = {1'b1, 3'(m_oaddr), 8'(p_re), 8'(p_im), p_ovf};
            e_rot   = {1'b1, 3'(m_oaddr), 8'(q_re), 8'(q_im), q_ovf};
        end else begin
            m_oaddr = 7;
        end
    endtask

    // ---------------- stimulus ----------------
    int fr_re[8];
    int fr_im[8];

    task automatic step(input bit en, input int k, input int re, input int im, input bit clr);
        logic [20:0] e0, e1;
        ien   = en;
        iaddr = 3'(k);
        idata = {8'(re), 8'(im)};
        iclr  = clr;
        model_cycle(e0, e1);
        @(posedge iclk);
        #1;
        check_eq({cur_test, "/plain"}, 32'({oen0, oaddr0, odata0, oovf0}), 32'(e0));
        check_eq({cur_test, "/rot"},   32'({oen1, oaddr1, odata1, oovf1}), 32'(e1));
        iclr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'b0);
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = k + 1;
            fr_im[k] = 0;
        end
    endtask

    task automatic set_ab(input int are, input int aim, input int bre, input int bim);
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = (k < D) ? are : bre;
            fr_im[k] = (k < D) ? aim : bim;
        end
    endtask

    task automatic run_frame(input bit sc, input int clr_at, input bit gaps);
        iscale = sc;
        for (int k = 0; k < 8; k++) begin
            if (gaps && k < D && $urandom_range(0, 3) == 0) idle(1);
            step(1'b1, k, fr_re[k], fr_im[k], k == clr_at);
            if (k == clr_at) break;
        end
    endtask

    initial begin
        rst = 1'b1; iclr = 1'b0; imode = 1'b0; iscale = 1'b0;
        ien = 1'b0; iaddr = '0; idata = '0;

        cur_test = "reset";
        for (int i = 0; i < 6; i++) begin
            step(1'(i % 2), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 1'b0);
        end
        rst = 1'b0;

        cur_test = "ramp";
        set_ramp();
        run_frame(1'b0, -1, 1'b0);
        idle(6);

        cur_test = "b2b";
        run_frame(1'b0, -1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 10 * k - 30;
            fr_im[k] = 5 - k;
        end
        run_frame(1'b0, -1, 1'b0);
        idle(6);

        cur_test = "sat";
        set_ab(100, 0, 100, 0);
        run_frame(1'b0, -1, 1'b0);
        run_frame(1'b1, -1, 1'b0);
        set_ab(3, 0, 0, 0);
        run_frame(1'b1, -1, 1'b0);
        idle(6);

        cur_test = "rot_fft";
        imode = 1'b0;
        set_ramp();
        run_frame(1'b0, -1, 1'b0);
        idle(6);

        cur_test = "rot_ifft";
        imode = 1'b1;
        run_frame(1'b0, -1, 1'b0);
        idle(6);

        cur_test = "rot_min";
        imode = 1'b0;
        set_ab(-100, 0, 28, 0);
        run_frame(1'b0, -1, 1'b0);
        idle(6);
        imode = 1'b1;
        set_ab(0, -100, 0, 28);
        run_frame(1'b0, -1, 1'b0);
        idle(6);

        cur_test = "clr";
        imode = 1'b0;
        set_ramp();
        run_frame(1'b0, 5, 1'b0);
        idle(3);
        run_frame(1'b0, -1, 1'b0);
        idle(6);

        cur_test = "rst_drain";
        run_frame(1'b0, -1, 1'b0);
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(3);
        run_frame(1'b0, -1, 1'b0);
        idle(6);

        cur_test = "random";
        for (int f = 0; f < 25; f++) begin
            imode = 1'($urandom_range(0, 1));
            for (int k = 0; k < 8; k++) begin
                fr_re[k] = int'($urandom_range(0, 255)) - 128;
                fr_im[k] = int'($urandom_range(0, 255)) - 128;
            end
            run_frame(1'($urandom_range(0, 1)), -1, 1'b1);
            idle(int'($urandom_range(0, 3)));
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
